// File: rtl/hack_data_memory_if.sv
// Hack data-port bundle: CPU load/store, keyboard capture and screen scan-out.
// The master side is the CPU/front ends; the slave side is the memory.
interface hack_data_memory_if;
    // CPU data port; words are two's complement
    logic [14:0] addressM;
    logic        writeM;
    logic [15:0] outM;
    logic [15:0] inM;

    // keyboard front end
    logic [15:0] key_code;
    logic        key_strobe;

    // screen scan-out stream
    logic        scan_ready;
    logic        scan_valid;
    logic [15:0] scan_word;
    logic        scan_sof;
    logic        scan_eol;
    logic [15:0] frame_count;

    modport master (
        output addressM,
        output writeM,
        output outM,
        output key_code,
        output key_strobe,
        output scan_ready,
        input  inM,
        input  scan_valid,
        input  scan_word,
        input  scan_sof,
        input  scan_eol,
        input  frame_count
    );

    modport slave (
        input  addressM,
        input  writeM,
        input  outM,
        input  key_code,
        input  key_strobe,
        input  scan_ready,
        output inM,
        output scan_valid,
        output scan_word,
        output scan_sof,
        output scan_eol,
        output frame_count
    );
endinterface

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, SCREEN and KBD behind the CPU data port,
// plus a free-running valid/ready scan-out of SCREEN, one word per transfer.
module hack_data_memory #(
    parameter int          RAM_WORDS    = 16384,
    parameter logic [14:0] SCREEN_BASE  = 15'h4000,
    parameter int          SCREEN_WORDS = 8192,
    parameter int          ROW_WORDS    = 32,
    parameter logic [14:0] KBD_ADDR     = 15'h6000
) (
    input  logic                CLK,
    input  logic                reset,
    hack_data_memory_if.slave   bus
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    localparam logic [14:0] LP_RAM_END = 15'(RAM_WORDS);
    localparam logic [14:0] LP_SCR_END = 15'(int'(SCREEN_BASE) + SCREEN_WORDS);

    // ROW_WORDS and SCREEN_WORDS are powers of two, so row end is a mask test
    localparam logic [SCR_AW-1:0] LP_ROW_MASK = SCR_AW'(ROW_WORDS - 1);
    localparam logic [SCR_AW-1:0] LP_PTR_LAST = SCR_AW'(SCREEN_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM
    } state_t;

    // storage; deliberately not cleared by reset
    logic [15:0] r_ram    [RAM_WORDS];
    logic [15:0] r_screen [SCREEN_WORDS];

    logic [15:0] r_kbd;

    state_t            r_state;
    logic [SCR_AW-1:0] r_ptr;
    logic              r_valid;
    logic [15:0]       r_word;
    logic              r_sof;
    logic              r_eol;
    logic [15:0]       r_frames;

    logic              w_ram_sel;
    logic              w_scr_sel;
    logic              w_kbd_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [SCR_AW-1:0] w_scr_idx;
    logic [15:0]       w_rdata;
    logic              w_xfer;
    logic [SCR_AW-1:0] w_ptr_nxt;

    assign w_ram_sel = (bus.addressM < LP_RAM_END);
    assign w_scr_sel = (bus.addressM >= SCREEN_BASE) &&
                       (bus.addressM < LP_SCR_END);
    assign w_kbd_sel = (bus.addressM == KBD_ADDR);

    assign w_ram_idx = RAM_AW'(bus.addressM);
    assign w_scr_idx = SCR_AW'(bus.addressM - SCREEN_BASE);

    assign w_xfer    = r_valid & bus.scan_ready;
    assign w_ptr_nxt = r_ptr + SCR_AW'(1);

    // CPU read mux: zero-latency, unmapped space reads as zero
    always_comb begin
        w_rdata = '0;
        if (w_ram_sel) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_scr_sel) begin
            w_rdata = r_screen[w_scr_idx];
        end else if (w_kbd_sel) begin
            w_rdata = r_kbd;
        end
    end

    assign bus.inM = w_rdata;

    // CPU stores to RAM/SCREEN; KBD and unmapped stores are dropped
    always_ff @(posedge CLK) begin
        if (bus.writeM) begin
            if (w_ram_sel) begin
                r_ram[w_ram_idx] <= bus.outM;
            end else if (w_scr_sel) begin
                r_screen[w_scr_idx] <= bus.outM;
            end
        end
    end

    // keyboard register: captures key_code on strobe, otherwise holds
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_kbd <= '0;
        end else if (bus.key_strobe) begin
            r_kbd <= bus.key_code;
        end
    end

    // scan FSM; fetches read the pre-edge array so a colliding
    // CPU store is seen by the scan only on the next frame
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_valid  <= 1'b0;
            r_word   <= '0;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
            r_frames <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_word  <= r_screen[r_ptr];
                    r_sof   <= (r_ptr == '0);
                    r_eol   <= ((r_ptr & LP_ROW_MASK) == LP_ROW_MASK);
                    r_valid <= 1'b1;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_ptr  <= w_ptr_nxt;
                        r_word <= r_screen[w_ptr_nxt];
                        r_sof  <= (w_ptr_nxt == '0);
                        r_eol  <= ((w_ptr_nxt & LP_ROW_MASK) == LP_ROW_MASK);
                        if (r_ptr == LP_PTR_LAST) begin
                            r_frames <= r_frames + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.scan_valid  = r_valid;
    assign bus.scan_word   = r_word;
    assign bus.scan_sof    = r_sof;
    assign bus.scan_eol    = r_eol;
    assign bus.frame_count = r_frames;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: memory map, keyboard register,
// scan-out timing, hold, collision, frame wrap and mid-stream reset.
module tb_hack_data_memory;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    hack_data_memory_if bus ();

    hack_data_memory dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        bus.addressM = a;
        bus.outM     = d;
        bus.writeM   = 1'b1;
        tick(1);
        bus.writeM   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [14:0] a,
                      input logic [15:0] exp);
        bus.addressM = a;
        #1;
        chk(tag, bus.inM, exp);
    endtask

    task automatic scan(input string tag, input logic v,
                        input logic [15:0] w, input logic s, input logic e);
        chk({tag, ".valid"}, {15'd0, bus.scan_valid}, {15'd0, v});
        chk({tag, ".word"}, bus.scan_word, w);
        chk({tag, ".sof"}, {15'd0, bus.scan_sof}, {15'd0, s});
        chk({tag, ".eol"}, {15'd0, bus.scan_eol}, {15'd0, e});
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        rst            = 1'b1;
        bus.addressM   = '0;
        bus.writeM     = 1'b0;
        bus.outM       = '0;
        bus.key_code   = '0;
        bus.key_strobe = 1'b0;
        bus.scan_ready = 1'b0;
        tick(2);

        // reset state
        scan("rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("rst.frames", bus.frame_count, 16'd0);
        rd("rst.kbd", 15'h6000, 16'h0000);

        // preload under reset; contents survive reset
        wr(15'h0010, 16'h1234);
        wr(15'h3FFF, 16'h7FFF);
        wr(15'h4000, 16'hAAAA);
        wr(15'h4001, 16'h5555);
        wr(15'h401F, 16'h1F1F);
        wr(15'h4020, 16'h2020);
        wr(15'h4021, 16'h3333);
        wr(15'h4064, 16'h0064);
        wr(15'h5FFF, 16'hCAFE);
        wr(15'h6001, 16'hDEAD);

        // T1 map reads
        rd("t1.ram10", 15'h0010, 16'h1234);
        rd("t1.ramtop", 15'h3FFF, 16'h7FFF);
        rd("t1.scr0", 15'h4000, 16'hAAAA);
        rd("t1.scrtop", 15'h5FFF, 16'hCAFE);
        rd("t1.unm6001", 15'h6001, 16'h0000);
        rd("t1.unm7fff", 15'h7FFF, 16'h0000);

        // T2 keyboard; scan starts but sink is stalled
        rst            = 1'b0;
        bus.key_code   = 16'h0041;
        bus.key_strobe = 1'b1;
        tick(1);
        bus.key_strobe = 1'b0;
        rd("t2.kbd", 15'h6000, 16'h0041);
        bus.key_code = 16'h0099;
        tick(1);
        rd("t2.hold", 15'h6000, 16'h0041);
        wr(15'h6000, 16'hFFFF);
        rd("t2.wrign", 15'h6000, 16'h0041);
        scan("t2.stall", 1'b1, 16'hAAAA, 1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        rd("t2.rstkbd", 15'h6000, 16'h0000);
        scan("t2.rst", 1'b0, 16'h0000, 1'b0, 1'b0);

        // T3 stream start
        bus.scan_ready = 1'b1;
        rst            = 1'b0;
        tick(1);
        chk("t3.c1valid", {15'd0, bus.scan_valid}, 16'd0);
        tick(1);
        scan("t3.w0", 1'b1, 16'hAAAA, 1'b1, 1'b0);
        tick(1);
        scan("t3.w1", 1'b1, 16'h5555, 1'b0, 1'b0);
        tick(30);
        scan("t3.w31", 1'b1, 16'h1F1F, 1'b0, 1'b1);
        tick(1);
        scan("t3.w32", 1'b1, 16'h2020, 1'b0, 1'b0);

        // T5 stalled word overwritten by CPU
        bus.scan_ready = 1'b0;
        wr(15'h4020, 16'hBEEF);
        tick(2);
        scan("t5.held", 1'b1, 16'h2020, 1'b0, 1'b0);
        rd("t5.cpu", 15'h4020, 16'hBEEF);

        // collision: fetch of word 33 and store to it on one edge
        bus.scan_ready = 1'b1;
        wr(15'h4021, 16'h2121);
        scan("col.old", 1'b1, 16'h3333, 1'b0, 1'b0);
        rd("col.cpu", 15'h4021, 16'h2121);

        // T6 reset at ptr 100
        tick(67);
        scan("t6.w100", 1'b1, 16'h0064, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        scan("t6.rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick(2);
        scan("t6.w0", 1'b1, 16'hAAAA, 1'b1, 1'b0);

        // T4 full frame and wrap
        tick(8191);
        scan("t4.w8191", 1'b1, 16'hCAFE, 1'b0, 1'b1);
        chk("t4.fc0", bus.frame_count, 16'd0);
        tick(1);
        scan("t4.wrap", 1'b1, 16'hAAAA, 1'b1, 1'b0);
        chk("t4.fc1", bus.frame_count, 16'd1);

        // T5 second frame picks up the stored values
        tick(32);
        scan("t5.new", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        tick(1);
        chk("col.new", bus.scan_word, 16'h2121);
        chk("t5.fc", bus.frame_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
